// File: rtl/conv_encoder.sv
// conv_encoder
// Rate-1/2, constraint-length-4 (8-state) convolutional encoder with optional zero-tail
// termination. One payload bit is accepted per cycle over a valid/ready stream and one
// 2-bit code symbol {c1, c0} is produced per bit through a single registered output slot.
// When tail termination is enabled, three zero bits follow each frame so that the trellis
// state returns to 0 and traceback on the receive side can start from state 0.
//
// Parameters
//   G0       generator for c0; bit 3 taps the current input u, bit 0 the oldest state bit
//   G1       generator for c1
//   TAIL_EN  1: append 3 zero tail bits after each in_last bit
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   enable     0 freezes FSM, tail counter and state register (output slot still drains)
//   in_valid   payload bit valid
//   in_bit     payload bit u
//   in_last    final payload bit of the frame
//   in_ready   encoder accepts a bit this cycle
//   out_valid  code symbol valid
//   out_c      code symbol {c1, c0}
//   out_last   final symbol of the frame
//   out_ready  downstream accepts the symbol
//   enc_state  shift-register state {s2, s1, s0}, s2 newest

module conv_encoder #(
   parameter logic [3:0] G0      = 4'b1101,
   parameter logic [3:0] G1      = 4'b1111,
   parameter bit         TAIL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       in_valid,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] out_c,
   output logic       out_last,
   input  logic       out_ready,
   output logic [2:0] enc_state
);

   typedef enum logic [0:0] {
      StData = 1'b0,
      StTail = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] tail_cnt_q, tail_cnt_d;
   logic [2:0] sr_q, sr_d;
   logic       out_valid_q, out_valid_d;
   logic [1:0] out_c_q, out_c_d;
   logic       out_last_q, out_last_d;

   logic       slot_free;
   logic       accept;
   logic       tail_step;
   logic       load;
   logic       enc_u;
   logic [3:0] window;
   logic [1:0] code;

   // ------------------------------------------------------------------
   // Code-bit generation. In TAIL the encoded bit is forced to zero;
   // in DATA it is the payload bit (only used when a bit is accepted).
   // ------------------------------------------------------------------
   always_comb begin
      enc_u  = (state_q == StData) ? in_bit : 1'b0;
      window = {enc_u, sr_q};
      code   = {^(window & G1), ^(window & G0)};
   end

   // ------------------------------------------------------------------
   // Handshake qualification. The output slot can take a new symbol when
   // it is empty or is being drained this same cycle, which gives one
   // symbol per cycle without a skid buffer. in_ready does not depend on
   // in_valid, so there is no combinational path from in_valid outward.
   // ------------------------------------------------------------------
   always_comb begin
      slot_free = !out_valid_q || out_ready;
      in_ready  = enable && (state_q == StData) && slot_free;
      accept    = in_valid && in_ready;
      tail_step = enable && (state_q == StTail) && slot_free;
      load      = accept || tail_step;
   end

   // ------------------------------------------------------------------
   // Next-state logic: FSM, tail counter, shift register, output slot.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      tail_cnt_d  = tail_cnt_q;
      sr_d        = sr_q;
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      out_last_d  = out_last_q;

      // Drain first; a load in the same cycle overrides it below.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_c_d     = code;
         out_last_d  = 1'b0;
         sr_d        = {enc_u, sr_q[2:1]};
      end

      unique case (state_q)
         StData: begin
            if (accept && in_last) begin
               if (TAIL_EN) begin
                  state_d    = StTail;
                  tail_cnt_d = 2'd0;
               end else begin
                  // Untermined frame: restart the next frame from state 0.
                  out_last_d = 1'b1;
                  sr_d       = 3'b000;
               end
            end
         end
         StTail: begin
            if (tail_step) begin
               if (tail_cnt_q == 2'd2) begin
                  // Three zeros have been shifted in, so sr_d is 0 here.
                  out_last_d = 1'b1;
                  state_d    = StData;
                  tail_cnt_d = 2'd0;
               end else begin
                  tail_cnt_d = tail_cnt_q + 2'd1;
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers with synchronous active-low reset. Reset discards
   // any pending symbol and any remaining tail bits.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StData;
         tail_cnt_q  <= 2'd0;
         sr_q        <= 3'b000;
         out_valid_q <= 1'b0;
         out_c_q     <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         if (enable) begin
            state_q    <= state_d;
            tail_cnt_q <= tail_cnt_d;
            sr_q       <= sr_d;
         end
         // The output slot keeps draining while enable is low; no load can
         // happen then because both accept and tail_step require enable.
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_c     = out_c_q;
   assign out_last  = out_last_q;
   assign enc_state = sr_q;

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       in_valid, in_bit, in_last, in_ready;
   logic       out_valid, out_last, out_ready;
   logic [1:0] out_c;
   logic [2:0] enc_state;

   logic       in_valid0, in_bit0, in_last0, in_ready0;
   logic       out_valid0, out_last0, out_ready0;
   logic [1:0] out_c0;
   logic [2:0] enc_state0;

   conv_encoder #(.G0(4'b1101), .G1(4'b1111), .TAIL_EN(1'b1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_c     (out_c),
      .out_last  (out_last),
      .out_ready (out_ready),
      .enc_state (enc_state)
   );

   conv_encoder #(.G0(4'b1101), .G1(4'b1111), .TAIL_EN(1'b0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid0),
      .in_bit    (in_bit0),
      .in_last   (in_last0),
      .in_ready  (in_ready0),
      .out_valid (out_valid0),
      .out_c     (out_c0),
      .out_last  (out_last0),
      .out_ready (out_ready0),
      .enc_state (enc_state0)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int stall_err = 0;
   int rdy_mode = 0;

   logic [2:0] got_q[$];
   int         got_cyc[$];
   logic [2:0] exp_q[$];
   int         hist[$];
   bit         frame_bits[64];
   bit         frame_last[64];
   logic [2:0] basic_exp[7] = '{3'b011, 3'b011, 3'b001, 3'b011, 3'b001, 3'b001, 3'b111};

   // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Symbol monitor, sampled mid-cycle: records each accepted symbol and
   // flags any change of a stalled symbol.
   logic       prev_stall = 1'b0;
   logic [2:0] prev_sym = 3'b000;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst && out_valid && out_ready) begin
         got_q.push_back({out_last, out_c});
         got_cyc.push_back(cyc);
      end
      if (rst && prev_stall && ({out_last, out_c} !== prev_sym)) stall_err = stall_err + 1;
      prev_stall = rst && out_valid && !out_ready;
      prev_sym   = {out_last, out_c};
   end

   // Reference: each code bit is the mod-2 sum of the generator-selected
   // bits among the current and three previous encoded bits of the frame.
   function automatic logic [1:0] conv_sym();
      logic [3:0] g0 = 4'b1101;
      logic [3:0] g1 = 4'b1111;
      int s0 = 0;
      int s1 = 0;
      int n = hist.size() - 1;
      for (int k = 0; k < 4; k++) begin
         if (n - k >= 0) begin
            if (g0[3-k]) s0 += hist[n-k];
            if (g1[3-k]) s1 += hist[n-k];
         end
      end
      return {(s1 % 2) != 0, (s0 % 2) != 0};
   endfunction

   task automatic build_expected(input int n, input bit tail_en);
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < n; i++) begin
         hist.push_back(int'(frame_bits[i]));
         if (frame_last[i] && !tail_en) exp_q.push_back({1'b1, conv_sym()});
         else exp_q.push_back({1'b0, conv_sym()});
         if (frame_last[i]) begin
            if (tail_en) begin
               for (int t = 0; t < 3; t++) begin
                  hist.push_back(0);
                  exp_q.push_back({t == 2, conv_sym()});
               end
            end
            hist.delete();
         end
      end
   endtask

   task automatic set_basic_frame();
      for (int i = 0; i < 64; i++) begin
         frame_bits[i] = 1'b0;
         frame_last[i] = 1'b0;
      end
      frame_bits[0] = 1'b1;
      frame_bits[2] = 1'b1;
      frame_bits[3] = 1'b1;
      frame_last[3] = 1'b1;
   endtask

   // Presents frame_bits[0..n-1]; returns at #1 after the last acceptance edge.
   task automatic drive_frames(input int n, input int gap_pct);
      bit acc;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_bit   = frame_bits[i];
         in_last  = frame_last[i];
         acc = 1'b0;
         for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) begin
            total++;
            bad++;
            $display("FAIL drive_timeout bit%0d got=no_accept exp=accept", i);
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_syms(input int n);
      for (int c = 0; c < 500 && got_q.size() < n; c++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_c !== 2'b00) begin bad++; $display("FAIL reset_out_c got=%b exp=00", out_c); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      total++; if (enc_state !== 3'b000) begin bad++; $display("FAIL reset_enc_state got=%b exp=000", enc_state); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      int low_cnt = 0;
      got_q.delete();
      rdy_mode = 0;
      set_basic_frame();
      @(posedge clk);
      #1;
      drive_frames(4, 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (in_ready) break;
         low_cnt++;
      end
      total++; if (low_cnt != 3) begin bad++; $display("FAIL basic_in_ready_low got=%0d exp=3", low_cnt); end
      total++; if (enc_state !== 3'b000) begin bad++; $display("FAIL basic_enc_state got=%b exp=000", enc_state); end
      wait_syms(7);
      total++; if (got_q.size() != 7) begin bad++; $display("FAIL basic_count got=%0d exp=7", got_q.size()); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
            bad++;
            $display("FAIL basic_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx,
                     basic_exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int se = stall_err;
      got_q.delete();
      rdy_mode = 1;
      set_basic_frame();
      drive_frames(4, 0);
      wait_syms(7);
      rdy_mode = 0;
      total++; if (got_q.size() != 7) begin bad++; $display("FAIL bp_count got=%0d exp=7", got_q.size()); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
            bad++;
            $display("FAIL bp_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx,
                     basic_exp[i]);
         end
      end
      total++; if (stall_err != se) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_err - se); end
   endtask

   task automatic test_back_to_back();
      got_q.delete();
      got_cyc.delete();
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) begin
         frame_bits[i] = 1'($urandom_range(1));
         frame_last[i] = (i == 3) || (i == 7);
      end
      frame_bits[4] = 1'b1;
      build_expected(8, 1'b1);
      drive_frames(8, 0);
      wait_syms(14);
      total++; if (got_q.size() != 14) begin bad++; $display("FAIL b2b_count got=%0d exp=14", got_q.size()); end
      if (got_q.size() == 14) begin
         total++;
         if (got_cyc[13] - got_cyc[0] != 13) begin
            bad++;
            $display("FAIL b2b_span got=%0d exp=13", got_cyc[13] - got_cyc[0]);
         end
         total++; if (got_q[7][1:0] !== 2'b11) begin bad++; $display("FAIL b2b_f2_first got=%b exp=11", got_q[7][1:0]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL b2b_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      int n = 0;
      got_q.delete();
      for (int f = 0; f < 4; f++) begin
         int len = int'($urandom_range(10, 1));
         for (int i = 0; i < len; i++) begin
            frame_bits[n] = 1'($urandom_range(1));
            frame_last[n] = (i == len - 1);
            n++;
         end
      end
      build_expected(n, 1'b1);
      rdy_mode = 2;
      drive_frames(n, 30);
      wait_syms(exp_q.size());
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_tail_en0();
      @(posedge clk);
      #1;
      in_valid0 = 1'b1; in_bit0 = 1'b1; in_last0 = 1'b0;
      @(negedge clk);
      total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL te0_ready got=%b exp=1", in_ready0); end
      @(posedge clk);
      #1;
      in_bit0 = 1'b1; in_last0 = 1'b1;
      total++;
      if ({out_valid0, out_last0, out_c0} !== 4'b1011) begin
         bad++;
         $display("FAIL te0_sym0 got=%b exp=1011", {out_valid0, out_last0, out_c0});
      end
      @(posedge clk);
      #1;
      in_valid0 = 1'b0; in_last0 = 1'b0;
      total++;
      if ({out_valid0, out_last0, out_c0} !== 4'b1100) begin
         bad++;
         $display("FAIL te0_sym1 got=%b exp=1100", {out_valid0, out_last0, out_c0});
      end
      total++; if (enc_state0 !== 3'b000) begin bad++; $display("FAIL te0_state got=%b exp=000", enc_state0); end
      @(posedge clk);
      #1;
      total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL te0_drain got=%b exp=0", out_valid0); end
   endtask

   task automatic test_enable_freeze();
      bit seen = 1'b0;
      got_q.delete();
      rdy_mode = 0;
      set_basic_frame();
      fork
         drive_frames(4, 0);
         begin
            // State 001 is reached only after the 2nd tail bit of this frame.
            for (int c = 0; c < 100 && !seen; c++) begin
               @(posedge clk);
               #1;
               seen = (enc_state == 3'b001);
            end
            enable = 1'b0;
         end
      join
      total++; if (!seen) begin bad++; $display("FAIL frz_reach got=no exp=state001"); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++; if (enc_state !== 3'b001) begin bad++; $display("FAIL frz_state%0d got=%b exp=001", c, enc_state); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL frz_ready%0d got=%b exp=0", c, in_ready); end
         @(posedge clk);
         #1;
      end
      total++; if (got_q.size() != 6) begin bad++; $display("FAIL frz_count got=%0d exp=6", got_q.size()); end
      enable = 1'b1;
      wait_syms(7);
      total++; if (got_q.size() != 7) begin bad++; $display("FAIL frz_total got=%0d exp=7", got_q.size()); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== basic_exp[i]) begin
            bad++;
            $display("FAIL frz_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx,
                     basic_exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_tail();
      bit seen = 1'b0;
      got_q.delete();
      rdy_mode = 0;
      set_basic_frame();
      drive_frames(4, 0);
      for (int c = 0; c < 50 && !seen; c++) begin
         seen = (enc_state == 3'b011);
         if (!seen) begin
            @(posedge clk);
            #1;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL rmt_reach got=no exp=state011"); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmt_valid got=%b exp=0", out_valid); end
      total++; if (enc_state !== 3'b000) begin bad++; $display("FAIL rmt_state got=%b exp=000", enc_state); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmt_ready got=%b exp=1", in_ready); end
      got_q.delete();
      frame_bits[0] = 1'b1;
      frame_last[0] = 1'b1;
      build_expected(1, 1'b1);
      @(posedge clk);
      #1;
      drive_frames(1, 0);
      wait_syms(4);
      total++;
      if (got_q.size() < 1 || got_q[0][1:0] !== 2'b11) begin
         bad++;
         $display("FAIL rmt_first got=%b exp=11", (got_q.size() > 0) ? got_q[0][1:0] : 2'bxx);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rmt_sym%0d got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 3'bxxx, exp_q[i]);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      enable = 1'b1;
      in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
      in_valid0 = 1'b0; in_bit0 = 1'b0; in_last0 = 1'b0;
      out_ready0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_tail_en0();
      test_enable_freeze();
      test_reset_mid_tail();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
